// File: rtl/baud_tick_gen.sv
// Baud generator: oversample tick, bit tick and 50% bit clock from clk_in,
// using either a preset divisor table or a programmed divisor with fractional accumulator.
module baud_tick_gen #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_SEL0   = 1302,
  parameter int DIV_SEL1   = 325,
  parameter int DIV_SEL2   = 163,
  parameter int DIV_SEL3   = 81
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        sel,
  input  logic              use_cfg,
  input  logic              cfg_we,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              clk_out
);

  localparam int PW  = DIV_W + 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

  function automatic logic [DIV_W-1:0] clamp2(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  logic [PW-1:0]     cyc_q, cyc_d;
  logic [PW-1:0]     per_q, per_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [OSW-1:0]    os_q, os_d;
  logic              run_q, run_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_bit_q, tick_bit_d;
  logic              clk_out_q, clk_out_d;
  logic [DIV_W-1:0]  cdiv_q, cdiv_d;
  logic [FRAC_W-1:0] cfrac_q, cfrac_d;

  logic [DIV_W-1:0]  preset_div;
  logic [DIV_W-1:0]  eff_div;
  logic [FRAC_W-1:0] eff_frac;
  logic [FRAC_W:0]   acc_sum;
  logic              period_end;
  logic              start;

  always_comb begin
    case (sel)
      2'b00:   preset_div = clamp2(DIV_W'(DIV_SEL0));
      2'b01:   preset_div = clamp2(DIV_W'(DIV_SEL1));
      2'b10:   preset_div = clamp2(DIV_W'(DIV_SEL2));
      default: preset_div = clamp2(DIV_W'(DIV_SEL3));
    endcase
  end

  // Divisor, fraction and select are only consumed on a period start, so
  // changes never shorten or stretch the period already in progress.
  assign eff_div    = use_cfg ? cdiv_q  : preset_div;
  assign eff_frac   = use_cfg ? cfrac_q : '0;
  assign acc_sum    = {1'b0, acc_q} + {1'b0, eff_frac};
  assign period_end = run_q && (cyc_q == per_q - PW'(1));
  assign start      = en && (!run_q || period_end);

  always_comb begin
    cyc_d      = cyc_q;
    per_d      = per_q;
    acc_d      = acc_q;
    os_d       = os_q;
    run_d      = run_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    clk_out_d  = clk_out_q;
    cdiv_d     = cdiv_q;
    cfrac_d    = cfrac_q;

    if (cfg_we) begin
      cdiv_d  = clamp2(cfg_div);
      cfrac_d = cfg_frac;
    end

    if (!en) begin
      cyc_d     = '0;
      acc_d     = '0;
      os_d      = '0;
      run_d     = 1'b0;
      clk_out_d = 1'b0;
    end else begin
      tick_os_d = period_end;
      if (start) begin
        run_d = 1'b1;
        cyc_d = '0;
        acc_d = acc_sum[FRAC_W-1:0];
        per_d = {1'b0, eff_div} + PW'(acc_sum[FRAC_W]);
      end else begin
        cyc_d = cyc_q + PW'(1);
      end
      if (period_end) begin
        if (os_q == OS_LAST) begin
          os_d       = '0;
          tick_bit_d = 1'b1;
          clk_out_d  = 1'b0;
        end else begin
          os_d = os_q + OSW'(1);
          if (os_q == OS_HALF) clk_out_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cyc_q      <= '0;
      per_q      <= {1'b0, preset_div};
      acc_q      <= '0;
      os_q       <= '0;
      run_q      <= 1'b0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
      clk_out_q  <= 1'b0;
      cdiv_q     <= clamp2(DIV_W'(DIV_SEL0));
      cfrac_q    <= '0;
    end else begin
      cyc_q      <= cyc_d;
      per_q      <= per_d;
      acc_q      <= acc_d;
      os_q       <= os_d;
      run_q      <= run_d;
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      clk_out_q  <= clk_out_d;
      cdiv_q     <= cdiv_d;
      cfrac_q    <= cfrac_d;
    end
  end

  assign tick_os  = tick_os_q;
  assign tick_bit = tick_bit_q;
  assign clk_out  = clk_out_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: default instance plus a narrow instance for boundary/clamp cases.
module tb_baud_tick_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        rst, en, use_cfg, cfg_we;
  logic [1:0]  sel;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_frac;
  logic        tick_os, tick_bit, clk_out;

  logic        s_rst, s_en, s_use_cfg, s_cfg_we;
  logic [1:0]  s_sel;
  logic [7:0]  s_cfg_div, s_cfg_frac;
  logic        s_tick_os, s_tick_bit, s_clk_out;

  baud_tick_gen dut (
    .clk_in(clk), .rst(rst), .en(en), .sel(sel), .use_cfg(use_cfg),
    .cfg_we(cfg_we), .cfg_div(cfg_div), .cfg_frac(cfg_frac),
    .tick_os(tick_os), .tick_bit(tick_bit), .clk_out(clk_out)
  );

  baud_tick_gen #(
    .DIV_W(8), .FRAC_W(8), .OVERSAMPLE(4),
    .DIV_SEL0(7), .DIV_SEL1(5), .DIV_SEL2(3), .DIV_SEL3(1)
  ) dut_s (
    .clk_in(clk), .rst(s_rst), .en(s_en), .sel(s_sel), .use_cfg(s_use_cfg),
    .cfg_we(s_cfg_we), .cfg_div(s_cfg_div), .cfg_frac(s_cfg_frac),
    .tick_os(s_tick_os), .tick_bit(s_tick_bit), .clk_out(s_clk_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] outs(input bit sm);
    return sm ? {s_tick_os, s_tick_bit, s_clk_out} : {tick_os, tick_bit, clk_out};
  endfunction

  // Waits (bounded) for the next tick_os pulse, returns the cycle it was seen in.
  task automatic wait_tick(input bit sm, input int budget, output longint t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sm ? s_tick_os : tick_os) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    tests++;
    assert (t >= 0) else begin
      fails++;
      $error("FAIL tick_timeout: no tick_os within %0d cycles", budget);
    end
  endtask

  // Reference: after a restart at edge t0 with constant D/F, period k is
  // D plus the carry of the k-th fractional addition; ticks are numbered from 1.
  task automatic check_ticks(input bit sm, input int d, input int f, input int os,
                             input int n, input longint t0, input string tag);
    longint exp_t = t0;
    longint t;
    for (int k = 0; k < n; k++) begin
      exp_t += d + ((longint'(k + 1) * f) >> 8) - ((longint'(k) * f) >> 8);
      wait_tick(sm, int'(exp_t - cyc) + 8, t);
      chk({tag, "_time"}, t, exp_t);
      chk({tag, "_tick_bit"}, sm ? s_tick_bit : tick_bit, ((k + 1) % os) == 0);
      chk({tag, "_clk_out"}, sm ? s_clk_out : clk_out, ((k + 1) % os) >= os / 2);
    end
  endtask

  task automatic reprogram(input bit sm, input int div, input int frac, output longint t0);
    @(negedge clk);
    if (sm) begin
      s_en = 0; s_cfg_we = 1; s_cfg_div = 8'(div); s_cfg_frac = 8'(frac); s_use_cfg = 1;
    end else begin
      en = 0; cfg_we = 1; cfg_div = 16'(div); cfg_frac = 8'(frac); use_cfg = 1;
    end
    @(negedge clk);
    chk("en_off_outputs", outs(sm), 3'b000);
    if (sm) begin s_cfg_we = 0; s_en = 1; end
    else begin cfg_we = 0; en = 1; end
    t0 = cyc + 1;
  endtask

  initial begin
    longint t0, t, tl;
    int div, frac;

    rst = 1; en = 1; sel = 2'b01; use_cfg = 0; cfg_we = 0; cfg_div = '0; cfg_frac = '0;
    s_rst = 1; s_en = 1; s_sel = 2'b11; s_use_cfg = 0; s_cfg_we = 0; s_cfg_div = '0; s_cfg_frac = '0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", outs(0), 3'b000);
      chk("reset_outputs_s", outs(1), 3'b000);
    end

    // Preset 9600: 325-cycle ticks, bit every 16 ticks, clk_out high for the second half.
    rst = 0;
    t0 = cyc + 1;
    check_ticks(0, 325, 0, 16, 32, t0, "preset9600");

    // Select change mid-period only affects the following periods.
    tl = cyc;
    repeat (100) @(negedge clk);
    sel = 2'b11;
    wait_tick(0, 240, t);
    chk("midchg_finish", t, tl + 325);
    wait_tick(0, 100, t);
    chk("midchg_new1", t, tl + 325 + 81);
    wait_tick(0, 100, t);
    chk("midchg_new2", t, tl + 325 + 162);

    // Fractional divisor 3.5: alternating 3,4 periods, exact average over 256 periods.
    reprogram(0, 3, 8'h80, t0);
    check_ticks(0, 3, 128, 16, 256, t0, "frac3p5");
    chk("frac_256_span", cyc - t0, 896);

    // Divisors 0 and 1 clamp to 2.
    reprogram(0, 0, 0, t0);
    check_ticks(0, 2, 0, 16, 6, t0, "clamp0");
    reprogram(0, 1, 0, t0);
    check_ticks(0, 2, 0, 16, 6, t0, "clamp1");

    for (int i = 0; i < 6; i++) begin
      div  = int'($urandom_range(0, 40));
      frac = int'($urandom_range(0, 255));
      reprogram(0, div, frac, t0);
      check_ticks(0, (div < 2) ? 2 : div, frac, 16, 20, t0, "random");
    end

    // Enable dropped with clk_out high; restart from phase 0.
    reprogram(0, 20, 0, t0);
    check_ticks(0, 20, 0, 16, 9, t0, "pre_drop");
    en = 0;
    @(negedge clk);
    chk("en_drop_outputs", outs(0), 3'b000);
    en = 1;
    t0 = cyc + 1;
    check_ticks(0, 20, 0, 16, 17, t0, "reenable");

    // Reset mid-bit reverts programmed config to the DIV_SEL0 preset.
    repeat (50) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_outputs", outs(0), 3'b000);
    @(negedge clk);
    chk("rst_mid_outputs2", outs(0), 3'b000);
    rst = 0;
    t0 = cyc + 1;
    check_ticks(0, 1302, 0, 16, 2, t0, "rst_revert");

    // Config write right at a tick: next period still old divisor.
    reprogram(0, 20, 0, t0);
    check_ticks(0, 20, 0, 16, 3, t0, "pre_simul");
    tl = cyc;
    cfg_we = 1; cfg_div = 16'd10;
    @(negedge clk);
    cfg_we = 0;
    wait_tick(0, 40, t);
    chk("simul_old", t, tl + 20);
    wait_tick(0, 40, t);
    chk("simul_new1", t, tl + 30);
    wait_tick(0, 40, t);
    chk("simul_new2", t, tl + 40);

    // Narrow instance: preset of 1 clamps to 2; max divisor plus carry does not wrap.
    @(negedge clk);
    chk("small_reset_outputs", outs(1), 3'b000);
    s_rst = 0;
    t0 = cyc + 1;
    check_ticks(1, 2, 0, 4, 8, t0, "small_preset_clamp");
    reprogram(1, 255, 255, t0);
    check_ticks(1, 255, 255, 4, 3, t0, "small_max");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
